// File: rtl/seven_seg_count_ctrl.sv
// Two-digit BCD up/down counter controller for a pair of seven-segment displays.
// Steps on button presses and auto-repeats while a button is held.
module seven_seg_count_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000,
  parameter bit          LEADING_BLANK = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Clear,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Tens_Blank,
  output logic       o_Update,
  output logic       o_Wrap
);

  localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int          TIMER_W   = $clog2(TIMER_MAX);

  localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  typedef struct packed {
    logic       wrap;
    logic [3:0] tens;
    logic [3:0] ones;
  } step_t;

  // Digit-wise BCD arithmetic: digits stay in 0-9, no binary intermediate.
  function automatic step_t bcd_up(input logic [3:0] t, input logic [3:0] o);
    step_t r;
    r.wrap = 1'b0;
    r.tens = t;
    r.ones = o + 4'd1;
    if (o == 4'd9) begin
      r.ones = 4'd0;
      if (t == 4'd9) begin
        r.tens = 4'd0;
        r.wrap = 1'b1;
      end else begin
        r.tens = t + 4'd1;
      end
    end
    return r;
  endfunction

  function automatic step_t bcd_down(input logic [3:0] t, input logic [3:0] o);
    step_t r;
    r.wrap = 1'b0;
    r.tens = t;
    r.ones = o - 4'd1;
    if (o == 4'd0) begin
      r.ones = 4'd9;
      if (t == 4'd0) begin
        r.tens = 4'd9;
        r.wrap = 1'b1;
      end else begin
        r.tens = t - 4'd1;
      end
    end
    return r;
  endfunction

  state_t             state;
  logic               dir;
  logic [TIMER_W-1:0] timer;
  logic               prev_up;
  logic               prev_down;

  logic  press_up;
  logic  press_down;
  logic  held;
  step_t up_res;
  step_t down_res;
  step_t rep_res;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    press_up   = 1'b0;
    press_down = 1'b0;
    held       = 1'b0;
    press_up   = i_Up & ~prev_up;
    press_down = i_Down & ~prev_down;
    held       = dir ? i_Down : i_Up;
    up_res     = bcd_up(o_Tens, o_Ones);
    down_res   = bcd_down(o_Tens, o_Ones);
    rep_res    = dir ? down_res : up_res;
  end

  assign o_Tens_Blank = LEADING_BLANK & (o_Tens == 4'd0);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      dir       <= 1'b0;
      timer     <= '0;
      prev_up   <= 1'b1;   // a button held through reset must be re-pressed
      prev_down <= 1'b1;
      o_Tens    <= 4'd0;
      o_Ones    <= 4'd0;
      o_Update  <= 1'b0;
      o_Wrap    <= 1'b0;
    end else begin
      prev_up   <= i_Up;
      prev_down <= i_Down;
      o_Update  <= 1'b0;
      o_Wrap    <= 1'b0;

      if (i_Clear) begin
        o_Tens   <= 4'd0;
        o_Ones   <= 4'd0;
        o_Update <= 1'b1;
        state    <= IDLE;
        timer    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press_up && press_down) begin
              o_Tens   <= 4'd0;
              o_Ones   <= 4'd0;
              o_Update <= 1'b1;
            end else if (press_up) begin
              o_Tens   <= up_res.tens;
              o_Ones   <= up_res.ones;
              o_Wrap   <= up_res.wrap;
              o_Update <= 1'b1;
              dir      <= 1'b0;
              timer    <= '0;
              state    <= DELAY;
            end else if (press_down) begin
              o_Tens   <= down_res.tens;
              o_Ones   <= down_res.ones;
              o_Wrap   <= down_res.wrap;
              o_Update <= 1'b1;
              dir      <= 1'b1;
              timer    <= '0;
              state    <= DELAY;
            end
          end

          DELAY: begin
            if (!held) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == DELAY_LAST) begin
              o_Tens   <= rep_res.tens;
              o_Ones   <= rep_res.ones;
              o_Wrap   <= rep_res.wrap;
              o_Update <= 1'b1;
              timer    <= '0;
              state    <= REPEAT;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end

          REPEAT: begin
            if (!held) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == PERIOD_LAST) begin
              o_Tens   <= rep_res.tens;
              o_Ones   <= rep_res.ones;
              o_Wrap   <= rep_res.wrap;
              o_Update <= 1'b1;
              timer    <= '0;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end

          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_count_ctrl.sv
// Directed self-checking bench for seven_seg_count_ctrl with short repeat timings.
module tb_seven_seg_count_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       i_Up = 1'b0;
  logic       i_Down = 1'b0;
  logic       i_Clear = 1'b0;
  logic [3:0] o_Tens;
  logic [3:0] o_Ones;
  logic       o_Tens_Blank;
  logic       o_Update;
  logic       o_Wrap;

  int errors = 0;
  int checks = 0;

  seven_seg_count_ctrl #(
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .LEADING_BLANK(1'b1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_Up        (i_Up),
    .i_Down      (i_Down),
    .i_Clear     (i_Clear),
    .o_Tens      (o_Tens),
    .o_Ones      (o_Ones),
    .o_Tens_Blank(o_Tens_Blank),
    .o_Update    (o_Update),
    .o_Wrap      (o_Wrap)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    i_Up = 0; i_Down = 0; i_Clear = 0;
    RST = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic press_up_n(input int n);
    for (int i = 0; i < n; i++) begin
      i_Up = 1; @(negedge CLK);
      i_Up = 0; @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    i_Up = 0; i_Down = 0; i_Clear = 0;
    RST = 1;
    @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h00) begin
      $display("FAIL reset_count: got %h want 00", {o_Tens, o_Ones}); errors++;
    end
    checks++;
    if ({o_Update, o_Wrap, o_Tens_Blank} !== 3'b001) begin
      $display("FAIL reset_flags: upd/wrap/blank got %b want 001", {o_Update, o_Wrap, o_Tens_Blank}); errors++;
    end
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_single_press();
    do_reset();
    i_Up = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h01 || o_Update !== 1'b1 || o_Tens_Blank !== 1'b1) begin
      $display("FAIL single_press: count %h upd %b blank %b want 01 1 1", {o_Tens, o_Ones}, o_Update, o_Tens_Blank); errors++;
    end
    i_Up = 0; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h01 || o_Update !== 1'b0) begin
      $display("FAIL single_press_after: count %h upd %b want 01 0", {o_Tens, o_Ones}, o_Update); errors++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    press_up_n(99);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h99 || o_Tens_Blank !== 1'b0) begin
      $display("FAIL preload_99: count %h blank %b want 99 0", {o_Tens, o_Ones}, o_Tens_Blank); errors++;
    end
    i_Up = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h00 || o_Wrap !== 1'b1 || o_Update !== 1'b1) begin
      $display("FAIL wrap_up: count %h wrap %b upd %b want 00 1 1", {o_Tens, o_Ones}, o_Wrap, o_Update); errors++;
    end
    i_Up = 0; @(negedge CLK);
    checks++;
    if (o_Wrap !== 1'b0) begin
      $display("FAIL wrap_up_pulse: wrap %b want 0", o_Wrap); errors++;
    end
    i_Down = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h99 || o_Wrap !== 1'b1 || o_Tens_Blank !== 1'b0) begin
      $display("FAIL wrap_down: count %h wrap %b blank %b want 99 1 0", {o_Tens, o_Ones}, o_Wrap, o_Tens_Blank); errors++;
    end
    i_Down = 0; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h99 || o_Wrap !== 1'b0) begin
      $display("FAIL wrap_down_hold: count %h wrap %b want 99 0", {o_Tens, o_Ones}, o_Wrap); errors++;
    end
  endtask

  task automatic test_auto_repeat();
    logic [7:0] exp_cnt;
    logic       exp_upd;
    do_reset();
    press_up_n(5);
    exp_cnt = 8'h05;
    i_Up = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      exp_upd = (k == 0 || k == 8 || k == 12 || k == 16);
      if (exp_upd) exp_cnt = exp_cnt + 8'h01;
      checks++;
      if ({o_Tens, o_Ones} !== exp_cnt || o_Update !== exp_upd) begin
        $display("FAIL repeat_cycle_%0d: count %h upd %b want %h %b", k, {o_Tens, o_Ones}, o_Update, exp_cnt, exp_upd); errors++;
      end
    end
    i_Up = 0;
    repeat (10) @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h09) begin
      $display("FAIL repeat_release: count %h want 09", {o_Tens, o_Ones}); errors++;
    end
    i_Up = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h10 || o_Tens_Blank !== 1'b0) begin
      $display("FAIL repeat_idle_press: count %h blank %b want 10 0", {o_Tens, o_Ones}, o_Tens_Blank); errors++;
    end
    i_Up = 0; @(negedge CLK);
  endtask

  task automatic test_clear_mid_delay();
    do_reset();
    press_up_n(10);
    i_Down = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h09) begin
      $display("FAIL clear_down_step: count %h want 09", {o_Tens, o_Ones}); errors++;
    end
    repeat (2) @(negedge CLK);
    i_Clear = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) i_Up = 1;  // this rising edge falls in a clear cycle
      @(negedge CLK);
      checks++;
      if ({o_Tens, o_Ones} !== 8'h00 || o_Update !== 1'b1 || o_Wrap !== 1'b0) begin
        $display("FAIL clear_cycle_%0d: count %h upd %b wrap %b want 00 1 0", k, {o_Tens, o_Ones}, o_Update, o_Wrap); errors++;
      end
    end
    i_Clear = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checks++;
      if ({o_Tens, o_Ones} !== 8'h00 || o_Update !== 1'b0) begin
        $display("FAIL clear_hold_%0d: count %h upd %b want 00 0", k, {o_Tens, o_Ones}, o_Update); errors++;
      end
    end
    i_Up = 0; i_Down = 0; @(negedge CLK);
  endtask

  task automatic test_both_press();
    do_reset();
    press_up_n(42);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h42) begin
      $display("FAIL both_preload: count %h want 42", {o_Tens, o_Ones}); errors++;
    end
    i_Up = 1; i_Down = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h00 || o_Wrap !== 1'b0 || o_Update !== 1'b1) begin
      $display("FAIL both_clear: count %h wrap %b upd %b want 00 0 1", {o_Tens, o_Ones}, o_Wrap, o_Update); errors++;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checks++;
      if ({o_Tens, o_Ones} !== 8'h00 || o_Update !== 1'b0) begin
        $display("FAIL both_hold_%0d: count %h upd %b want 00 0", k, {o_Tens, o_Ones}, o_Update); errors++;
      end
    end
    i_Up = 0; i_Down = 0; @(negedge CLK);
  endtask

  task automatic test_reset_hold();
    i_Up = 1; i_Down = 0; i_Clear = 0;
    RST = 1;
    @(negedge CLK);
    RST = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checks++;
      if ({o_Tens, o_Ones} !== 8'h00 || o_Update !== 1'b0) begin
        $display("FAIL held_through_reset_%0d: count %h upd %b want 00 0", k, {o_Tens, o_Ones}, o_Update); errors++;
      end
    end
    i_Up = 0; @(negedge CLK);
    i_Up = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h01 || o_Update !== 1'b1) begin
      $display("FAIL repress_after_reset: count %h upd %b want 01 1", {o_Tens, o_Ones}, o_Update); errors++;
    end
    i_Up = 0; @(negedge CLK);
    // Hold into REPEAT: steps after edges 0 and 8 give 03.
    i_Up = 1;
    repeat (10) @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h03) begin
      $display("FAIL reach_repeat: count %h want 03", {o_Tens, o_Ones}); errors++;
    end
    #1 RST = 1;
    #1;
    checks++;
    if ({o_Tens, o_Ones} !== 8'h00 || o_Update !== 1'b0 || o_Wrap !== 1'b0) begin
      $display("FAIL async_reset: count %h upd %b wrap %b want 00 0 0", {o_Tens, o_Ones}, o_Update, o_Wrap); errors++;
    end
    @(negedge CLK);
    RST = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checks++;
      if ({o_Tens, o_Ones} !== 8'h00 || o_Update !== 1'b0) begin
        $display("FAIL after_repeat_reset_%0d: count %h upd %b want 00 0", k, {o_Tens, o_Ones}, o_Update); errors++;
      end
    end
    i_Up = 0; @(negedge CLK);
    i_Up = 1; @(negedge CLK);
    checks++;
    if ({o_Tens, o_Ones} !== 8'h01) begin
      $display("FAIL final_repress: count %h want 01", {o_Tens, o_Ones}); errors++;
    end
    i_Up = 0; @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_wrap();
    test_auto_repeat();
    test_clear_mid_delay();
    test_both_press();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_count_ctrl.md
Name: seven_seg_count_ctrl

Overview:
Control block for a two-digit decimal counter (00-99) that drives a pair of seven-segment displays. It takes debounced Up/Down/Clear switch levels and steps a BCD count on each press. A held button auto-repeats after a delay. Its outputs feed two binary-to-seven-segment decoders, one per digit.

Parameters:
REPEAT_DELAY, 12500000, clocks a button must be held after the initial step before the first auto-repeat step (0.5 s at 25 MHz); must be >= 2
REPEAT_PERIOD, 2500000, clocks between auto-repeat steps (0.1 s at 25 MHz); must be >= 2
LEADING_BLANK, 1, 1 = assert o_Tens_Blank when the tens digit is 0; 0 = never blank

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
i_Up  input  1  debounced level, synchronous to CLK, 1 = pressed
i_Down  input  1  debounced level, synchronous to CLK, 1 = pressed
i_Clear  input  1  synchronous level, 1 = force count to 00
o_Tens  output  4  BCD tens digit, 0-9
o_Ones  output  4  BCD ones digit, 0-9
o_Tens_Blank  output  1  tens digit should be blanked (leading zero)
o_Update  output  1  one-cycle pulse: count changed or was cleared this cycle
o_Wrap  output  1  one-cycle pulse: step wrapped (99->00 up, 00->99 down)

Behaviour:
- Reset (RST high, async):
  - o_Tens=0, o_Ones=0, o_Update=0, o_Wrap=0; o_Tens_Blank follows LEADING_BLANK.
  - FSM=IDLE, timer=0.
  - Previous-level registers for i_Up and i_Down reset to 1, so a button held through reset release does not count. It must be released and pressed again.
- Press detect: press_X = i_X & ~prev_X, with prev_X registered every cycle.
- Step latency: a step or clear decided in cycle N shows on o_Tens/o_Ones in cycle N+1. o_Update (and o_Wrap if applicable) is high in cycle N+1 only.
- BCD step rules:
  - Up: ones 9 -> 0 with tens+1; 99 -> 00 with o_Wrap.
  - Down: ones 0 -> 9 with tens-1; 00 -> 99 with o_Wrap.
  - No binary intermediate; digits never leave 0-9.
- FSM states: IDLE, DELAY, REPEAT. The register dir (0=up, 1=down) is latched on entry to DELAY.
  - IDLE:
    - press_Up & press_Down in the same cycle: clear to 00, stay IDLE.
    - press_Up only: step up, dir=0, timer=0, go to DELAY.
    - press_Down only: step down, dir=1, timer=0, go to DELAY.
  - DELAY:
    - Held button (selected by dir) low: go to IDLE, timer=0, no step.
    - Else, if timer==REPEAT_DELAY-1: step in dir, timer=0, go to REPEAT.
    - Else timer+1.
  - REPEAT:
    - Held button low: go to IDLE.
    - Else, if timer==REPEAT_PERIOD-1: step, timer=0.
    - Else timer+1.
  - In DELAY/REPEAT, presses of the other button are ignored. Holding both does not stop repeat; only release of the held button ends it.
- i_Clear: highest priority, evaluated every cycle.
  - Count -> 00, FSM -> IDLE, timer=0.
  - o_Update pulses in the following cycle for each cycle Clear is high. o_Wrap=0.
  - Presses in a Clear cycle are discarded.
- o_Tens_Blank: combinational, equal to LEADING_BLANK & (o_Tens==0).
- Timer width: $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD). The timer never exceeds its terminal value.
- RST mid-DELAY/REPEAT: immediate return to the reset state. No further steps until release and re-press.

Test Plan:
(Sim params: REPEAT_DELAY=8, REPEAT_PERIOD=4.)
1. Reset, pulse i_Up high for 1 cycle at count 00 -> count 01 one cycle after the press, o_Update high for exactly 1 cycle, o_Tens_Blank=1.
2. Preload 99 via 99 Up presses, then 1 Up press -> count 00 with o_Wrap=1. Then 1 Down press -> 99 with o_Wrap=1, o_Tens_Blank=0.
3. Hold i_Up from count 05 for 20 cycles, then release -> steps occur at press+1, +9, +13, +17. Final count 09, FSM back to IDLE.
4. Hold i_Down at count 10, assert i_Clear for 3 cycles mid-DELAY -> count 00, o_Update pulses 3 times, no steps while Up/Down stay held with no new press.
5. Rising edges on i_Up and i_Down in the same cycle at count 42 -> count 00, o_Wrap=0, FSM stays IDLE. Holding both afterwards produces no steps.
6. Hold i_Up through RST deassert -> no step. Release then press -> count 01. Assert RST during REPEAT -> outputs 00 immediately, no steps until re-press.
